// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, word-length encodings and helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      START,
      DATA,
      PAR,
      STOP1,
      STOP2
   } tx_state_t;

   localparam logic [1:0] WLS_5 = 2'b00;
   localparam logic [1:0] WLS_6 = 2'b01;
   localparam logic [1:0] WLS_7 = 2'b10;
   localparam logic [1:0] WLS_8 = 2'b11;

   function automatic logic [3:0] word_len(input logic [1:0] wls);
      return 4'd5 + {2'b00, wls};
   endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational UART parity over the active data bits; shared by transmitter and receiver.
module uart_parity_gen
   import uart_pkg::*;
(
   input  logic [7:0] i_data,
   input  logic [1:0] i_wls,
   input  logic       i_eps,
   input  logic       i_sp,
   output logic       o_parity
);

   logic [7:0] w_mask;
   logic       w_xor;

   always_comb begin
      w_mask = 8'hFF;
      case (i_wls)
         WLS_5:   w_mask = 8'h1F;
         WLS_6:   w_mask = 8'h3F;
         WLS_7:   w_mask = 8'h7F;
         WLS_8:   w_mask = 8'hFF;
         default: w_mask = 8'hFF;
      endcase
   end

   assign w_xor    = ^(i_data & w_mask);
   // Stick parity forces the bit to the inverse of EPS regardless of data.
   assign o_parity = i_sp ? ~i_eps : (i_eps ? w_xor : ~w_xor);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 5-8 data bits LSB first, optional parity, 1-2 stop bits,
// advanced by the one-cycle bit-rate enable from the clock divider.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W = 8
)
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              BITCE,
   input  logic              TXSTART,
   input  logic [DATA_W-1:0] DIN,
   input  logic [1:0]        WLS,
   input  logic              STB,
   input  logic              PEN,
   input  logic              EPS,
   input  logic              SP,
   input  logic              BC,
   output logic              TXD,
   output logic              BUSY,
   output logic              TXFINISHED
);

   tx_state_t         r_state;
   logic [2:0]        r_cnt;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_wls;
   logic              r_stb;
   logic              r_pen;
   logic              r_eps;
   logic              r_sp;
   logic              r_line;
   logic              r_txd;
   logic              r_busy;
   logic              r_fin;

   tx_state_t         w_state_nxt;
   logic [2:0]        w_cnt_nxt;
   logic [2:0]        w_cnt_inc;
   logic              w_line_nxt;
   logic              w_busy_nxt;
   logic              w_fin_nxt;
   logic              w_load;
   logic              w_last;
   logic              w_parity;

   uart_parity_gen u_parity (
      .i_data   (r_data),
      .i_wls    (r_wls),
      .i_eps    (r_eps),
      .i_sp     (r_sp),
      .o_parity (w_parity)
   );

   assign w_cnt_inc = r_cnt + 3'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_line_nxt  = r_line;
      w_busy_nxt  = r_busy;
      w_fin_nxt   = 1'b0;
      w_load      = 1'b0;
      w_last      = ({1'b0, r_cnt} == (word_len(r_wls) - 4'd1));
      case (r_state)
         IDLE: begin
            w_line_nxt = 1'b1;
            if (TXSTART) begin
               w_load      = 1'b1;
               w_busy_nxt  = 1'b1;
               w_state_nxt = WAIT;
            end
         end
         WAIT: if (BITCE) begin
            w_line_nxt  = 1'b0;
            w_state_nxt = START;
         end
         START: if (BITCE) begin
            w_line_nxt  = r_data[0];
            w_cnt_nxt   = 3'd0;
            w_state_nxt = DATA;
         end
         DATA: if (BITCE) begin
            if (w_last) begin
               w_line_nxt  = r_pen ? w_parity : 1'b1;
               w_state_nxt = r_pen ? PAR : STOP1;
            end else begin
               w_cnt_nxt  = w_cnt_inc;
               w_line_nxt = r_data[w_cnt_inc];
            end
         end
         PAR: if (BITCE) begin
            w_line_nxt  = 1'b1;
            w_state_nxt = STOP1;
         end
         STOP1: if (BITCE) begin
            if (r_stb) begin
               w_state_nxt = STOP2;
            end else begin
               w_state_nxt = IDLE;
               w_busy_nxt  = 1'b0;
               w_fin_nxt   = 1'b1;
            end
         end
         STOP2: if (BITCE) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_fin_nxt   = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // The FSM line level lives in r_line so a break can clamp TXD without losing it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_data  <= '0;
         r_wls   <= '0;
         r_stb   <= 1'b0;
         r_pen   <= 1'b0;
         r_eps   <= 1'b0;
         r_sp    <= 1'b0;
         r_line  <= 1'b1;
         r_txd   <= 1'b1;
         r_busy  <= 1'b0;
         r_fin   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_line  <= w_line_nxt;
         r_txd   <= BC ? 1'b0 : w_line_nxt;
         r_busy  <= w_busy_nxt;
         r_fin   <= w_fin_nxt;
         if (w_load) begin
            r_data <= DIN;
            r_wls  <= WLS;
            r_stb  <= STB;
            r_pen  <= PEN;
            r_eps  <= EPS;
            r_sp   <= SP;
         end
      end
   end

   assign TXD        = r_txd;
   assign BUSY       = r_busy;
   assign TXFINISHED = r_fin;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: frame-level reference model checked every cycle,
// table of hand-computed frames, and hand-written corner-case sequences.
module tb_uart_tx_serializer;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       BITCE = 1'b0;
   logic       TXSTART = 1'b0;
   logic [7:0] DIN = '0;
   logic [1:0] WLS = '0;
   logic       STB = 1'b0;
   logic       PEN = 1'b0;
   logic       EPS = 1'b0;
   logic       SP = 1'b0;
   logic       BC = 1'b0;
   logic       TXD;
   logic       BUSY;
   logic       TXFINISHED;

   int n_chk = 0;
   int n_err = 0;
   int cyc_count = 0;

   uart_tx_serializer #(.DATA_W(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .BITCE      (BITCE),
      .TXSTART    (TXSTART),
      .DIN        (DIN),
      .WLS        (WLS),
      .STB        (STB),
      .PEN        (PEN),
      .EPS        (EPS),
      .SP         (SP),
      .BC         (BC),
      .TXD        (TXD),
      .BUSY       (BUSY),
      .TXFINISHED (TXFINISHED)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // Reference model: the accepted frame is a list of line levels; BITCE count since
   // acceptance indexes that list, and one more BITCE ends the frame.
   logic        m_line = 1'b1;
   logic        m_busy = 1'b0;
   logic        m_fin = 1'b0;
   logic        m_txd = 1'b1;
   logic [11:0] m_frame = '1;
   int          m_len = 0;
   int          m_k = 0;
   int          m_frames = 0;

   int div = 4;
   int ph = 0;

   function automatic int frame_len(input logic [1:0] w, input logic s, input logic p);
      return 1 + (5 + int'(w)) + (p ? 1 : 0) + 1 + (s ? 1 : 0);
   endfunction

   function automatic logic [11:0] frame_bits(input logic [7:0] d, input logic [1:0] w,
                                              input logic p, input logic e, input logic s);
      logic [11:0] f;
      int wl;
      int ones;
      f    = '1;
      wl   = 5 + int'(w);
      ones = 0;
      f[0] = 1'b0;
      for (int i = 0; i < wl; i++) begin
         f[1 + i] = d[i];
         if (d[i]) ones++;
      end
      if (p) begin
         if (s)      f[1 + wl] = ~e;
         else if (e) f[1 + wl] = ((ones % 2) == 1);
         else        f[1 + wl] = ((ones % 2) == 0);
      end
      return f;
   endfunction

   task automatic model_reset();
      m_line = 1'b1;
      m_busy = 1'b0;
      m_fin  = 1'b0;
      m_txd  = 1'b1;
      m_k    = 0;
   endtask

   task automatic model_step();
      m_fin = 1'b0;
      if (!m_busy) begin
         m_line = 1'b1;
         if (TXSTART) begin
            m_frame = frame_bits(DIN, WLS, PEN, EPS, SP);
            m_len   = frame_len(WLS, STB, PEN);
            m_k     = 0;
            m_busy  = 1'b1;
         end
      end else if (BITCE) begin
         m_k++;
         if (m_k <= m_len) begin
            m_line = m_frame[m_k - 1];
         end else begin
            m_busy = 1'b0;
            m_fin  = 1'b1;
            m_line = 1'b1;
            m_frames++;
         end
      end
      m_txd = BC ? 1'b0 : m_line;
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_bitce();
      if (div == 0) begin
         BITCE = ($urandom_range(0, 2) == 0);
      end else begin
         BITCE = (ph == 0);
         ph    = (ph + 1) % div;
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      if (RST) model_reset();
      else     model_step();
      cyc_count++;
      #1;
      chk1("txd", TXD, m_txd);
      chk1("busy", BUSY, m_busy);
      chk1("txfinished", TXFINISHED, m_fin);
   endtask

   task automatic async_reset_pulse(input string nm);
      #2 RST = 1'b1;
      #1;
      model_reset();
      chk1({nm, "_txd"}, TXD, 1'b1);
      chk1({nm, "_busy"}, BUSY, 1'b0);
      chk1({nm, "_fin"}, TXFINISHED, 1'b0);
      #1 RST = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         set_bitce();
         cyc();
         if (!BUSY) done = 1'b1;
      end
      chki({nm, "_idle"}, int'(done), 1);
   endtask

   typedef struct {
      string       name;
      logic [7:0]  din;
      logic [1:0]  wls;
      logic        stb;
      logic        pen;
      logic        eps;
      logic        sp;
      logic [11:0] bits;
      int          len;
   } vec_t;

   task automatic run_vec(input vec_t t);
      logic [11:0] cap;
      int          ncap;
      int          nfin;
      bit          done;
      logic        b;
      cap  = '1;
      ncap = 0;
      nfin = 0;
      done = 1'b0;
      div  = 4;
      ph   = 1;
      DIN = t.din; WLS = t.wls; STB = t.stb; PEN = t.pen; EPS = t.eps; SP = t.sp;
      BC = 1'b0;
      TXSTART = 1'b1;
      set_bitce();
      cyc();
      TXSTART = 1'b0;
      chk1({t.name, "_accept"}, BUSY, 1'b1);
      for (int c = 0; c < 400 && !done; c++) begin
         DIN = 8'($urandom_range(0, 255));
         WLS = 2'($urandom_range(0, 3));
         STB = 1'($urandom_range(0, 1));
         PEN = 1'($urandom_range(0, 1));
         EPS = 1'($urandom_range(0, 1));
         SP  = 1'($urandom_range(0, 1));
         set_bitce();
         b = BITCE;
         cyc();
         if (TXFINISHED) nfin++;
         if (b) begin
            if (BUSY) begin
               if (ncap < 12) cap[ncap] = TXD;
               ncap++;
            end else begin
               done = 1'b1;
            end
         end
      end
      chki({t.name, "_done"}, int'(done), 1);
      for (int c = 0; c < 3; c++) begin
         set_bitce();
         cyc();
         if (TXFINISHED) nfin++;
      end
      chki({t.name, "_len"}, ncap, t.len);
      chki({t.name, "_finpulses"}, nfin, 1);
      for (int i = 0; i < t.len && i < 12; i++)
         chk1($sformatf("%s_bit%0d", t.name, i), cap[i], t.bits[i]);
   endtask

   vec_t vecs[6];
   int   divs[6];

   initial begin
      bit done;
      int start_cyc;
      int nfin;
      int bc_left;

      vecs[0] = '{"8N1_55",     8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 12'h2AA, 10};
      vecs[1] = '{"5E1_FF",     8'hFF, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 12'h0FE, 8};
      vecs[2] = '{"7O2_03",     8'h03, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 12'h706, 11};
      vecs[3] = '{"8S1_eps1",   8'h01, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 12'h402, 11};
      vecs[4] = '{"8S1_eps0",   8'h01, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 12'h602, 11};
      vecs[5] = '{"6E1_21",     8'h21, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 12'h142, 9};
      divs    = '{0, 1, 2, 3, 4, 7};

      // Reset state
      RST = 1'b1;
      cyc();
      cyc();
      chk1("reset_txd", TXD, 1'b1);
      chk1("reset_busy", BUSY, 1'b0);
      chk1("reset_fin", TXFINISHED, 1'b0);
      RST = 1'b0;
      cyc();

      foreach (vecs[v]) run_vec(vecs[v]);

      // TXSTART held through the whole frame, including the final BITCE edge
      div = 4; ph = 1;
      DIN = 8'h15; WLS = 2'b00; STB = 1'b0; PEN = 1'b0; EPS = 1'b0; SP = 1'b0; BC = 1'b0;
      TXSTART = 1'b1;
      set_bitce();
      cyc();
      chk1("hold_accept", BUSY, 1'b1);
      wait_idle("hold");
      chk1("hold_fin", TXFINISHED, 1'b1);
      TXSTART = 1'b0;
      for (int c = 0; c < 3; c++) begin
         set_bitce();
         cyc();
         chk1("hold_no_requeue", BUSY, 1'b0);
      end

      // Accept in the first IDLE cycle with a coincident BITCE that must not count
      TXSTART = 1'b1;
      set_bitce();
      cyc();
      wait_idle("hold2");
      chk1("hold2_fin", TXFINISHED, 1'b1);
      BITCE = 1'b1;
      cyc();
      TXSTART = 1'b0;
      chk1("reaccept_busy", BUSY, 1'b1);
      chk1("coinc_bitce_ignored", TXD, 1'b1);
      BITCE = 1'b0;
      cyc();
      cyc();
      chk1("wait_holds_mark", TXD, 1'b1);
      BITCE = 1'b1;
      cyc();
      chk1("start_bit", TXD, 1'b0);
      ph = 1;
      wait_idle("reaccept");

      // Break for 3 bit periods mid-frame; frame timing must be unchanged
      div = 4; ph = 0;
      DIN = 8'hA5; WLS = 2'b11; STB = 1'b0; PEN = 1'b0;
      TXSTART = 1'b1;
      set_bitce();
      cyc();
      TXSTART = 1'b0;
      start_cyc = cyc_count;
      for (int c = 0; c < 8; c++) begin
         set_bitce();
         cyc();
      end
      BC = 1'b1;
      for (int c = 0; c < 12; c++) begin
         set_bitce();
         cyc();
         chk1("break_low", TXD, 1'b0);
      end
      BC = 1'b0;
      set_bitce();
      cyc();
      chk1("break_still_busy", BUSY, 1'b1);
      wait_idle("break");
      chki("break_frame_cycles", cyc_count - start_cyc, 44);

      // Reset mid-frame aborts with no finish pulse
      TXSTART = 1'b1;
      set_bitce();
      cyc();
      TXSTART = 1'b0;
      for (int c = 0; c < 10; c++) begin
         set_bitce();
         cyc();
      end
      async_reset_pulse("mid_rst");
      nfin = 0;
      for (int c = 0; c < 60; c++) begin
         set_bitce();
         cyc();
         if (TXFINISHED) nfin++;
      end
      chki("mid_rst_no_fin", nfin, 0);

      // Randomized traffic against the model, including BITCE stuck high
      m_frames = 0;
      bc_left = 0;
      for (int c = 0; c < 4000; c++) begin
         if ((c % 500) == 0) begin
            div = divs[(c / 500) % 6];
            ph  = 0;
         end
         DIN     = 8'($urandom_range(0, 255));
         WLS     = 2'($urandom_range(0, 3));
         STB     = 1'($urandom_range(0, 1));
         PEN     = 1'($urandom_range(0, 1));
         EPS     = 1'($urandom_range(0, 1));
         SP      = 1'($urandom_range(0, 1));
         TXSTART = ($urandom_range(0, 5) == 0);
         if (bc_left > 0) begin
            BC = 1'b1;
            bc_left--;
         end else begin
            BC = 1'b0;
            if ($urandom_range(0, 299) == 0) bc_left = $urandom_range(1, 10);
         end
         set_bitce();
         cyc();
         if ($urandom_range(0, 1499) == 0) async_reset_pulse("rand_rst");
      end
      chki("rand_frames_seen", int'(m_frames > 20), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit serializer that consumes the single-cycle bit-rate enable produced by the clock divider (one pulse per bit period). It takes one parallel character from the TX FIFO/holding-register logic and shifts it out on TXD. The frame is start bit, 5–8 data bits LSB first, optional parity, and 1 or 2 stop bits. It reports busy and end-of-frame back to the line-control/interrupt logic.

Parameters:
- DATA_W, 8, width of DIN; maximum word length. Must be 8 in this design.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- BITCE  in  1  bit-period enable, 1-cycle pulse from clock divider Q
- TXSTART  in  1  start request; sampled only in IDLE
- DIN  in  8  character to send; bits above word length ignored
- WLS  in  2  word length: 00=5, 01=6, 10=7, 11=8
- STB  in  1  0=1 stop bit, 1=2 stop bits
- PEN  in  1  parity enable
- EPS  in  1  1=even parity, 0=odd parity
- SP  in  1  stick parity
- BC  in  1  break control
- TXD  out  1  serial output, registered
- BUSY  out  1  frame in progress, registered
- TXFINISHED  out  1  1-cycle pulse at end of frame, registered

Behaviour:
- Reset (async) values: TXD=1, BUSY=0, TXFINISHED=0, state IDLE, bit counter 0, data/config shadow 0.
- States: IDLE, WAIT, START, DATA, PAR, STOP1, STOP2. Every transition except IDLE->WAIT happens only on BITCE=1.
- IDLE: TXD=1. If TXSTART=1:
  - latch DIN, WLS, STB, PEN, EPS and SP into shadow registers;
  - set BUSY=1 and go to WAIT.
  - Changes to config inputs after this point have no effect on the current frame.
- WAIT, on BITCE: TXD<=0 (start bit), go to START. A BITCE coincident with acceptance does not count; the start bit begins at the next BITCE.
- START, on BITCE: TXD<=data[0], cnt<=0, go to DATA.
- DATA, on BITCE:
  - if cnt==WL-1 (WL = 5+WLS): if PEN, TXD<=parity and go to PAR; else TXD<=1 and go to STOP1;
  - otherwise cnt<=cnt+1 and TXD<=data[cnt+1].
- PAR, on BITCE: TXD<=1, go to STOP1.
- STOP1, on BITCE: if STB, go to STOP2 (TXD stays 1); else finish.
- STOP2, on BITCE: finish.
- Finish: state<=IDLE, BUSY<=0, TXFINISHED<=1 for exactly one cycle. TXFINISHED is visible in the cycle after the final BITCE.
- Every line level is held for exactly one BITCE-to-BITCE interval. Frame length is 1+WL+PEN+(1+STB) bit periods.
- Parity is computed over the masked data bits only:
  - SP=0, EPS=1: parity = XOR(bits).
  - SP=0, EPS=0: parity = ~XOR(bits).
  - SP=1: parity = ~EPS.
- Break: while BC=1 the TXD register is loaded with 0 each cycle. The internal FSM keeps running. When BC falls, TXD resumes the current FSM level on the next cycle.
- TXSTART while BUSY=1, including the finish cycle, is ignored and not queued. It can be accepted from the first IDLE cycle onward.
- RST asserted mid-frame aborts immediately: TXD=1, BUSY=0, and no TXFINISHED pulse.
- BITCE stuck high is legal and gives one bit per clock.

Decomposition:
- Shared package uart_pkg holds:
  - the tx_state_t enum (IDLE, WAIT, START, DATA, PAR, STOP1, STOP2);
  - WLS encoding constants WLS_5/6/7/8;
  - a function returning the word length from WLS.
- One sub-module, uart_parity_gen: combinational; inputs data[7:0], WLS, EPS, SP; output parity bit. It is reused by the receiver's parity check.
- Bit counter (3 bits) and shift/index logic stay inline.

Test Plan:
- 8N1, DIN=0x55, BITCE every 4 clocks, TXSTART pulse -> TXD = 0,1,0,1,0,1,0,1,0 then 1, each level held 4 clocks. BUSY is high for 10 bit periods plus WAIT. One TXFINISHED pulse.
- 5E1, WLS=00, PEN=1, EPS=1, DIN=0xFF -> data bits 1,1,1,1,1, parity 1, stop 1. Frame is 8 bit periods. DIN[7:5] do not affect parity.
- 7O2, WLS=10, PEN=1, EPS=0, STB=1, DIN=0x03 -> data 1,1,0,0,0,0,0, parity 1, two stop bits. 11 bit periods total.
- Stick parity: SP=1, EPS=1, 8-bit, DIN=0x01 -> parity bit 0. With EPS=0 -> parity bit 1.
- TXSTART held during a frame, plus TXSTART in the finish cycle -> no second frame. TXSTART one cycle later -> new frame, and its start bit begins at the next BITCE.
- BC=1 for 3 bit periods mid-frame -> TXD=0 throughout and the frame timing is unchanged. Then RST pulse mid-frame -> TXD=1 and BUSY=0 immediately, with no TXFINISHED.
